xy_route_arbiter: RTL and testbench
===================================

Name: xy_route_arbiter

Overview:
Upstream companion of the switch control unit in the simple_mesh_xy router. It looks at the head flit of every input FIFO whose control-unit valid bit is set and computes that flit's XY output port. It then picks one input per grant using round-robin arbitration. It drives the input-mux select, the output-mux select and the select-valid strobe, and holds them stable until the control unit reports the write.

Parameters:
PORT_N, 5, number of router ports; port index 0=N, 1=E, 2=S, 3=W, 4=Local.
DATA_W, 8, flit width.
COORD_W, 2, width of each destination coordinate field.
ROW_CORD, 0, this router's row (Y); Y increases southward.
COL_CORD, 0, this router's column (X); X increases eastward.

Ports:
clk_i  in  1  clock, all state updates on rising edge.
rst_ni  in  1  synchronous active-low reset.
vld_input_i  in  PORT_N  head-flit-valid per input (control unit vld_input_o).
data_i  in  PORT_N*DATA_W  head flits, port p at bits [p*DATA_W +: DATA_W].
wr_en_i  in  PORT_N  output write strobes (control unit wr_en_o).
mux_in_sel_o  out  $clog2(PORT_N)  granted input index.
mux_in_sel_vld_o  out  1  grant active.
mux_out_sel_o  out  $clog2(PORT_N)  output port for the granted flit.

Behaviour:
- Flit fields:
  - dst_x = flit[DATA_W-1 -: COORD_W].
  - dst_y = flit[DATA_W-1-COORD_W -: COORD_W].
  - All coordinate comparisons are unsigned.
- XY route function, X first:
  - dst_x > COL_CORD gives E (1); dst_x < COL_CORD gives W (3).
  - Otherwise dst_y < ROW_CORD gives N (0); dst_y > ROW_CORD gives S (2).
  - Otherwise Local (4).
  - Purely combinational on the selected flit. No U-turn check.
- State: IDLE, GRANT. Registers: state, rr_ptr, sel_in, sel_out.
- Reset (rst_ni=0 at clock edge):
  - state=IDLE, rr_ptr=0, sel_in=0, sel_out=0.
  - Outputs are 0 the cycle after the reset edge, including when reset lands mid-GRANT.
- Arbitration over a request mask M, starting at pointer P:
  - Winner is the first set bit of M scanning P, P+1, …, PORT_N-1, 0, …, P-1.
  - No winner if M=0.
- IDLE:
  - M=vld_input_i, P=rr_ptr.
  - If a winner w exists: next cycle state=GRANT, sel_in=w, sel_out=route(data_i[w]).
  - Arbitration latency is 1 cycle from vld_input_i to mux_in_sel_vld_o.
- GRANT:
  - mux_in_sel_vld_o=1; mux_in_sel_o=sel_in; mux_out_sel_o=sel_out.
  - Transfer condition: wr_en_i[sel_out]=1.
  - No transfer: hold all outputs and rr_ptr unchanged. This covers output-full back-pressure of any length. No preemption, even if other inputs become valid.
  - On transfer: rr_ptr <= (sel_in+1) mod PORT_N (wrap from PORT_N-1 to 0). Then re-arbitrate in the same cycle with M=vld_input_i & ~(1<<sel_in) and P=(sel_in+1) mod PORT_N.
    - Winner exists: stay in GRANT with the new sel_in/sel_out, giving back-to-back, one-flit-per-cycle throughput.
    - No winner: go to IDLE.
- Any wr_en_i bit other than sel_out while in GRANT is ignored. wr_en_i in IDLE is ignored.
- vld_input_i[sel_in] dropping during GRANT without a transfer is a protocol violation. Behaviour is undefined; cover it with a formal assume.
- Outputs are registered only; there is no combinational path from inputs to outputs.
- Formal asserts:
  - mux_in_sel_vld_o implies mux_in_sel_o < PORT_N.
  - Selections are stable while vld=1 and no transfer.
  - mux_out_sel_o equals route(data_i[mux_in_sel_o]).

Test Plan:
- Reset: hold rst_ni=0 for 2 cycles with random inputs → all outputs 0; rr_ptr=0, observed via the first grant order.
- Single request, ROW_CORD=1, COL_CORD=1: vld_input_i=5'b10000, flit 8'hC0 (x=3, y=0) → next cycle in_sel=4, out_sel=1, vld=1. Then wr_en_i=5'b00010 for 1 cycle with vld_input_i=0 → vld=0 the following cycle.
- Route coverage at router (1,1), one request each:
  - x=0 → out 3.
  - x=1, y=0 → out 0.
  - x=1, y=2 → out 2.
  - x=1, y=1 → out 4.
- Round-robin back-to-back: vld_input_i=5'b00101, rr_ptr=0 → grant 0. Transfer → next cycle grant 2 with no bubble. Transfer → IDLE with rr_ptr=3. Then inputs 1 and 4 valid → grant 4 first, then 1 (wrap).
- Back-pressure: grant in=3 out=1, wr_en_i=0 for 10 cycles while input 0 becomes valid → selections stable all 10 cycles; input 0 is granted only after wr_en_i[1]=1.
- Reset mid-GRANT: rst_ni=0 for 1 cycle during an active grant → next cycle vld=0, sels=0; with requests still pending, re-arbitration starts from ptr 0.

Source files
------------

// File: rtl/xy_route_arbiter_if.sv
// Request/grant bundle between the XY route arbiter and the switch control unit.
// The arbiter takes the slave modport; the control unit (or a bench) takes master.
interface xy_route_arbiter_if #(
    parameter int PORT_N = 5,
    parameter int DATA_W = 8
);
    localparam int SEL_W = $clog2(PORT_N);

    logic [PORT_N-1:0]        vld_input_i;
    logic [PORT_N*DATA_W-1:0] data_i;
    logic [PORT_N-1:0]        wr_en_i;
    logic [SEL_W-1:0]         mux_in_sel_o;
    logic                     mux_in_sel_vld_o;
    logic [SEL_W-1:0]         mux_out_sel_o;

    modport slave (
        input  vld_input_i, data_i, wr_en_i,
        output mux_in_sel_o, mux_in_sel_vld_o, mux_out_sel_o
    );

    modport master (
        output vld_input_i, data_i, wr_en_i,
        input  mux_in_sel_o, mux_in_sel_vld_o, mux_out_sel_o
    );
endinterface

// File: rtl/xy_route_arbiter.sv
// XY route computation plus round-robin input arbitration for the simple_mesh_xy router.
// Grants are held until the control unit writes the selected output port.
module xy_route_arbiter #(
    parameter int PORT_N   = 5,
    parameter int DATA_W   = 8,
    parameter int COORD_W  = 2,
    parameter int ROW_CORD = 0,
    parameter int COL_CORD = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    xy_route_arbiter_if.slave    bus
);
    localparam int SEL_W = $clog2(PORT_N);
    localparam logic [COORD_W-1:0] MY_X = COORD_W'(COL_CORD);
    localparam logic [COORD_W-1:0] MY_Y = COORD_W'(ROW_CORD);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0]   sel_in_q, sel_in_d;
    logic [SEL_W-1:0]   sel_out_q, sel_out_d;

    logic [DATA_W-1:0]  flit [PORT_N];
    logic [PORT_N-1:0]  req;
    logic [SEL_W-1:0]   ptr;
    logic               do_arb;
    logic               found;
    logic [SEL_W-1:0]   win;

    function automatic logic [SEL_W-1:0] route(input logic [DATA_W-1:0] f);
        logic [COORD_W-1:0] dx;
        logic [COORD_W-1:0] dy;
        dx = f[DATA_W-1 -: COORD_W];
        dy = f[DATA_W-1-COORD_W -: COORD_W];
        if (dx > MY_X)      return SEL_W'(1);
        else if (dx < MY_X) return SEL_W'(3);
        else if (dy < MY_Y) return SEL_W'(0);
        else if (dy > MY_Y) return SEL_W'(2);
        else                return SEL_W'(4);
    endfunction

    function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] i);
        return (i == SEL_W'(PORT_N-1)) ? '0 : i + 1'b1;
    endfunction

    // First set bit of m scanning circularly upward from p.
    function automatic void arbitrate(input  logic [PORT_N-1:0] m,
                                      input  logic [SEL_W-1:0]  p,
                                      output logic              f,
                                      output logic [SEL_W-1:0]  w);
        logic [SEL_W-1:0] idx;
        f   = 1'b0;
        w   = '0;
        idx = p;
        for (int unsigned i = 0; i < PORT_N; i++) begin
            if (!f && m[idx]) begin
                f = 1'b1;
                w = idx;
            end
            idx = next_idx(idx);
        end
    endfunction

    always_comb begin
        for (int unsigned p = 0; p < PORT_N; p++) begin
            flit[p] = bus.data_i[p*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        sel_in_d  = sel_in_q;
        sel_out_d = sel_out_q;
        req       = '0;
        ptr       = '0;
        do_arb    = 1'b0;
        found     = 1'b0;
        win       = '0;

        case (state_q)
            IDLE: begin
                req    = bus.vld_input_i;
                ptr    = rr_ptr_q;
                do_arb = 1'b1;
            end
            GRANT: begin
                // On a write, re-arbitrate immediately excluding the input just served.
                if (bus.wr_en_i[sel_out_q]) begin
                    rr_ptr_d = next_idx(sel_in_q);
                    req      = bus.vld_input_i & ~(PORT_N'(1) << sel_in_q);
                    ptr      = next_idx(sel_in_q);
                    do_arb   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        arbitrate(req, ptr, found, win);

        if (do_arb) begin
            if (found) begin
                state_d   = GRANT;
                sel_in_d  = win;
                sel_out_d = route(flit[win]);
            end else begin
                state_d   = IDLE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            sel_in_q  <= '0;
            sel_out_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            sel_in_q  <= sel_in_d;
            sel_out_q <= sel_out_d;
        end
    end

    assign bus.mux_in_sel_o     = sel_in_q;
    assign bus.mux_out_sel_o    = sel_out_q;
    assign bus.mux_in_sel_vld_o = (state_q == GRANT);

    // The granted head flit must stay valid until it is written.
    m_hold_vld: assume property (@(posedge clk_i) disable iff (!rst_ni)
        (bus.mux_in_sel_vld_o && !bus.wr_en_i[bus.mux_out_sel_o])
            |-> bus.vld_input_i[bus.mux_in_sel_o]);

    a_sel_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.mux_in_sel_vld_o |-> (32'(bus.mux_in_sel_o) < PORT_N));

    a_sel_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (bus.mux_in_sel_vld_o && !bus.wr_en_i[bus.mux_out_sel_o])
            |=> (bus.mux_in_sel_vld_o && $stable(bus.mux_in_sel_o) && $stable(bus.mux_out_sel_o)));

    a_route_ok: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.mux_in_sel_vld_o |-> (bus.mux_out_sel_o == route(flit[bus.mux_in_sel_o])));

endmodule

// File: tb/tb_xy_route_arbiter.sv
// Directed table-driven bench for xy_route_arbiter at router (row 1, col 1).
module tb_xy_route_arbiter;
    localparam int PORT_N = 5;
    localparam int DATA_W = 8;

    logic clk;
    logic rst_n;

    xy_route_arbiter_if #(.PORT_N(PORT_N), .DATA_W(DATA_W)) bus ();

    xy_route_arbiter #(
        .PORT_N  (PORT_N),
        .DATA_W  (DATA_W),
        .COORD_W (2),
        .ROW_CORD(1),
        .COL_CORD(1)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic [4:0]  vld;
        logic [4:0]  wr;
        logic [39:0] data;
        logic        e_vld;
        logic [2:0]  e_in;
        logic [2:0]  e_out;
        logic        chk_sel;
        string       name;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    // Head flits {p4,p3,p2,p1,p0}; routes at (1,1): p0 W(3), p1 N(0), p2 S(2), p3 L(4), p4 E(1).
    logic [39:0] D  = {8'hC0, 8'h50, 8'h60, 8'h40, 8'h10};
    // Same but p3 carries x=3,y=1 so it routes E(1).
    logic [39:0] D2 = {8'hC0, 8'hD0, 8'h60, 8'h40, 8'h10};

    function automatic vec_t mk(input logic r, input logic [4:0] v, input logic [4:0] w,
                                input logic [39:0] d, input logic ev, input logic [2:0] ei,
                                input logic [2:0] eo, input logic cs, input string nm);
        vec_t x;
        x.rst_n = r; x.vld = v; x.wr = w; x.data = d;
        x.e_vld = ev; x.e_in = ei; x.e_out = eo; x.chk_sel = cs; x.name = nm;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Drive at the falling edge, let one rising edge pass, check at the next falling edge.
    task automatic step(input vec_t v);
        rst_n           = v.rst_n;
        bus.vld_input_i = v.vld;
        bus.wr_en_i     = v.wr;
        bus.data_i      = v.data;
        @(posedge clk);
        @(negedge clk);
        chk({v.name, ".vld"}, 32'(bus.mux_in_sel_vld_o), 32'(v.e_vld));
        if (v.e_vld || v.chk_sel) begin
            chk({v.name, ".in"},  32'(bus.mux_in_sel_o),  32'(v.e_in));
            chk({v.name, ".out"}, 32'(bus.mux_out_sel_o), 32'(v.e_out));
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.vld_input_i = '0;
        bus.wr_en_i     = '0;
        bus.data_i      = '0;

        tbl.push_back(mk(0, 5'($urandom), 5'($urandom), {$urandom, 8'($urandom)}, 0, 0, 0, 1, "rst0"));
        tbl.push_back(mk(0, 5'($urandom), 5'($urandom), {$urandom, 8'($urandom)}, 0, 0, 0, 1, "rst1"));
        tbl.push_back(mk(1, 5'b10000, 5'b00000, D, 1, 4, 1, 0, "single_grant"));
        tbl.push_back(mk(1, 5'b00000, 5'b00010, D, 0, 0, 0, 0, "single_done"));
        tbl.push_back(mk(1, 5'b00001, 5'b00000, D, 1, 0, 3, 0, "route_w"));
        tbl.push_back(mk(1, 5'b00000, 5'b01000, D, 0, 0, 0, 0, "route_w_done"));
        tbl.push_back(mk(1, 5'b00010, 5'b00000, D, 1, 1, 0, 0, "route_n"));
        tbl.push_back(mk(1, 5'b00000, 5'b00001, D, 0, 0, 0, 0, "route_n_done"));
        tbl.push_back(mk(1, 5'b00100, 5'b00000, D, 1, 2, 2, 0, "route_s"));
        tbl.push_back(mk(1, 5'b00000, 5'b00100, D, 0, 0, 0, 0, "route_s_done"));
        tbl.push_back(mk(1, 5'b01000, 5'b00000, D, 1, 3, 4, 0, "route_l"));
        tbl.push_back(mk(1, 5'b01000, 5'b01011, D, 1, 3, 4, 0, "wrong_wr_ignored"));
        tbl.push_back(mk(1, 5'b00000, 5'b10000, D, 0, 0, 0, 0, "route_l_done"));
        tbl.push_back(mk(1, 5'b00000, 5'b11111, D, 0, 0, 0, 0, "idle_wr_ignored"));
        tbl.push_back(mk(0, 5'b00000, 5'b00000, D, 0, 0, 0, 1, "rst_again"));
        tbl.push_back(mk(1, 5'b00101, 5'b00000, D, 1, 0, 3, 0, "rr_first0"));
        tbl.push_back(mk(1, 5'b00101, 5'b01000, D, 1, 2, 2, 0, "rr_b2b2"));
        tbl.push_back(mk(1, 5'b00100, 5'b00100, D, 0, 0, 0, 0, "rr_to_idle"));
        tbl.push_back(mk(1, 5'b10010, 5'b00000, D, 1, 4, 1, 0, "rr_ptr3_grant4"));
        tbl.push_back(mk(1, 5'b10010, 5'b00010, D, 1, 1, 0, 0, "rr_wrap_grant1"));
        tbl.push_back(mk(1, 5'b00010, 5'b00001, D, 0, 0, 0, 0, "rr_wrap_idle"));

        @(negedge clk);
        foreach (tbl[i]) step(tbl[i]);

        // Back-pressure: input 3 (routed E) held for 10 cycles while input 0 waits.
        step(mk(1, 5'b01000, 5'b00000, D2, 1, 3, 1, 0, "bp_grant"));
        for (int i = 0; i < 10; i++) begin
            step(mk(1, 5'b01001, 5'b00000, D2, 1, 3, 1, 0, $sformatf("bp_hold%0d", i)));
        end
        step(mk(1, 5'b01001, 5'b00010, D2, 1, 0, 3, 0, "bp_release"));
        step(mk(1, 5'b00001, 5'b01000, D2, 0, 0, 0, 0, "bp_idle"));

        // Reset mid-grant: pointer is 1 here, so a surviving pointer would pick input 2.
        step(mk(1, 5'b00100, 5'b00000, D, 1, 2, 2, 0, "mid_grant"));
        step(mk(0, 5'b00101, 5'b00000, D, 0, 0, 0, 1, "mid_rst"));
        step(mk(1, 5'b00101, 5'b00000, D, 1, 0, 3, 0, "post_rst_ptr0"));
        step(mk(1, 5'b00100, 5'b01000, D, 1, 2, 2, 0, "post_rst_next"));
        step(mk(1, 5'b00000, 5'b00100, D, 0, 0, 0, 0, "post_rst_idle"));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
